// File: rtl/embedding_fetch.sv
// Embedding vector fetch: reads DIM words at token*DIM from a fixed-latency RAM into a local
// buffer (overwrite or accumulate), then streams the buffer out over a valid/ready interface.
module embedding_fetch #(
  parameter int DATA_W  = 32,
  parameter int DIM     = 16,
  parameter int TOKEN_W = 7,
  parameter int ADDR_W  = 27,
  parameter int RD_LAT  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [TOKEN_W-1:0]      token,
  output logic                    ram_en,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(DIM)-1:0]  out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W  = $clog2(DIM);
  localparam int PROD_W = ADDR_W + TOKEN_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, STREAM, DONE} state_t;

  state_t            state_reg;
  logic              mode_reg;
  logic              cap_done_reg;
  logic [IDX_W-1:0]  fetch_cnt_reg;
  logic [DATA_W-1:0] buffer [DIM];
  logic              vld_pipe [RD_LAT];
  logic [IDX_W-1:0]  idx_pipe [RD_LAT];
  logic              cap_valid;
  logic [IDX_W-1:0]  cap_idx;
  logic [ADDR_W-1:0] base_addr;

  // Widen before multiplying so the product wraps modulo 2^ADDR_W after truncation.
  assign base_addr = ADDR_W'(PROD_W'(token) * PROD_W'(DIM));
  assign cap_valid = vld_pipe[RD_LAT-1];
  assign cap_idx   = idx_pipe[RD_LAT-1];

  // Tracks which element each outstanding read belongs to, aligned with RAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[0] <= 1'b0;
      idx_pipe[0] <= '0;
    end else begin
      vld_pipe[0] <= ram_en;
      idx_pipe[0] <= fetch_cnt_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_pipe
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_pipe[gi] <= 1'b0;
          idx_pipe[gi] <= '0;
        end else begin
          vld_pipe[gi] <= vld_pipe[gi-1];
          idx_pipe[gi] <= idx_pipe[gi-1];
        end
      end
    end

    for (gi = 0; gi < DIM; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (reset) begin
          buffer[gi] <= '0;
        end else if (cap_valid && cap_idx == IDX_W'(gi)) begin
          buffer[gi] <= mode_reg ? buffer[gi] + ram_rdata : ram_rdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      cap_done_reg  <= 1'b0;
      fetch_cnt_reg <= '0;
      ram_en        <= 1'b0;
      ram_addr      <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_index     <= '0;
      out_last      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cap_valid && cap_idx == LAST_IDX) cap_done_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= FETCH;
            mode_reg      <= mode;
            cap_done_reg  <= 1'b0;
            fetch_cnt_reg <= '0;
            ram_en        <= 1'b1;
            ram_addr      <= base_addr;
            busy          <= 1'b1;
          end
        end
        FETCH: begin
          if (fetch_cnt_reg == LAST_IDX) begin
            state_reg     <= DRAIN;
            fetch_cnt_reg <= '0;
            ram_en        <= 1'b0;
            ram_addr      <= '0;
          end else begin
            fetch_cnt_reg <= fetch_cnt_reg + IDX_W'(1);
            ram_addr      <= ram_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Final element was captured on the previous edge, so buffer[0] is settled.
          if (cap_done_reg) begin
            state_reg    <= STREAM;
            cap_done_reg <= 1'b0;
            out_valid    <= 1'b1;
            out_index    <= '0;
            out_data     <= buffer[0];
            out_last     <= 1'b0;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              state_reg <= DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              out_index <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_index <= out_index + IDX_W'(1);
              out_data  <= buffer[out_index + IDX_W'(1)];
              out_last  <= (out_index + IDX_W'(1)) == LAST_IDX;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_embedding_fetch.sv
// Scoreboard bench for embedding_fetch: stimulus queues expected reads and outputs,
// a negedge monitor pops and compares whenever the DUT reads or hands off a word.
module tb_embedding_fetch;
  localparam int DATA_W = 32, DIM = 16, TOKEN_W = 7, ADDR_W = 27, RD_LAT = 2;
  localparam int LAT = DIM + RD_LAT + 1;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, out_ready = 1'b1;
  logic [TOKEN_W-1:0] token = '0;
  logic ram_en, out_valid, out_last, busy, done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata, out_data;
  logic [3:0] out_index;

  embedding_fetch #(.DATA_W(DATA_W), .DIM(DIM), .TOKEN_W(TOKEN_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .token(token),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc_ctr = 0, done_cnt = 0, first_valid_cyc = -1;
  int ram_mode = 0;  // 0: data = address, 1: all ones, 2: constant 1

  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  // RAM model: data for a read in cycle c appears during cycle c+RD_LAT.
  logic [ADDR_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= ram_addr;
    for (int j = 1; j < RD_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
  end
  always_comb begin
    ram_rdata = 32'(rd_pipe[RD_LAT-1]);
    if (ram_mode == 1) ram_rdata = 32'hFFFF_FFFF;
    else if (ram_mode == 2) ram_rdata = 32'd1;
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [3:0]        idx;
    logic              last;
  } out_t;
  logic [ADDR_W-1:0] exp_addr_q[$];
  out_t              exp_out_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_ctr);
    end
  endtask

  // Monitor
  logic stalled_prev = 1'b0, last_hs_prev = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [3:0] prev_index;
  always @(negedge clk) begin
    if (reset) begin
      stalled_prev = 1'b0;
      last_hs_prev = 1'b0;
    end else begin
      if (ram_en) begin
        if (exp_addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_read: ram_addr %0d, expected no read (cycle %0d)", ram_addr, cyc_ctr);
        end else check("ram_addr", 64'(ram_addr), 64'(exp_addr_q.pop_front()));
      end
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc_ctr;
        check("busy_in_stream", 64'(busy), 64'd1);
        if (stalled_prev) begin
          check("stall_data", 64'(out_data), 64'(prev_data));
          check("stall_index", 64'(out_index), 64'(prev_index));
        end
        if (out_ready) begin
          if (exp_out_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output: index %0d data 0x%0h, expected none", out_index, out_data);
          end else begin
            out_t e;
            e = exp_out_q.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_index", 64'(out_index), 64'(e.idx));
            check("out_last", 64'(out_last), 64'(e.last));
          end
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_last", 64'(last_hs_prev), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
      end
      last_hs_prev = out_valid && out_ready && out_last;
      stalled_prev = out_valid && !out_ready;
      prev_data    = out_data;
      prev_index   = out_index;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ram_en"},    64'(ram_en), 0);
    check({tag, "_ram_addr"},  64'(ram_addr), 0);
    check({tag, "_out_valid"}, 64'(out_valid), 0);
    check({tag, "_out_data"},  64'(out_data), 0);
    check({tag, "_out_index"}, 64'(out_index), 0);
    check({tag, "_out_last"},  64'(out_last), 0);
    check({tag, "_busy"},      64'(busy), 0);
    check({tag, "_done"},      64'(done), 0);
  endtask

  // One fetch: expected reads base..base+15, outputs d0 + i*dstep.
  task automatic run_op(input logic m, input logic [TOKEN_W-1:0] tok, input logic [ADDR_W-1:0] base,
                        input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] dstep,
                        input bit toggle_ready, input bit glitch, input string tag);
    int t0, rel, done0;
    for (int i = 0; i < DIM; i++) begin
      out_t e;
      exp_addr_q.push_back(base + ADDR_W'(i));
      e.data = d0 + dstep * 32'(i);
      e.idx  = 4'(i);
      e.last = (i == DIM - 1);
      exp_out_q.push_back(e);
    end
    first_valid_cyc = -1;
    done0 = done_cnt;
    mode = m; token = tok; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    t0 = cyc_ctr;
    start = 1'b0; token = 7'd9; mode = ~m;
    for (int k = 0; k < 300; k++) begin
      rel = cyc_ctr - t0;
      out_ready = toggle_ready ? ((rel % 4) == 0 || (rel % 4) == 3) : 1'b1;
      start = glitch && (rel == 5 || rel == 25);
      @(posedge clk); #1;
      if (done_cnt != done0) break;
    end
    start = 1'b0; out_ready = 1'b1;
    check({tag, "_done_seen"}, 64'(done_cnt - done0), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_single_done"}, 64'(done_cnt - done0), 64'd1);
    check({tag, "_latency"}, 64'(first_valid_cyc - t0), 64'(LAT));
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_reads_left"}, 64'(exp_addr_q.size()), 64'd0);
    check({tag, "_outputs_left"}, 64'(exp_out_q.size()), 64'd0);
    exp_addr_q.delete();
    exp_out_q.delete();
  endtask

  // Start a LOAD of token 3 and reset it in its eighth FETCH cycle.
  task automatic reset_mid_fetch(input string tag);
    int t0, done0;
    done0 = done_cnt;
    for (int i = 0; i < DIM; i++) exp_addr_q.push_back(ADDR_W'(48 + i));
    mode = 1'b0; token = 7'd3; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc_ctr;
    start = 1'b0;
    while (cyc_ctr - t0 < 7) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs(tag);
    reset = 1'b0;
    exp_addr_q.delete();
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_no_done"}, 64'(done_cnt - done0), 64'd0);
    check({tag, "_quiet"}, 64'(ram_en | out_valid | busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("post_reset_idle");

    run_op(1'b0, 7'd5, 27'd80, 32'd80, 32'd1, 1'b0, 1'b0, "load_t5");
    run_op(1'b1, 7'd1, 27'd16, 32'd96, 32'd2, 1'b0, 1'b0, "add_t1");
    ram_mode = 1;
    run_op(1'b0, 7'd0, 27'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, "load_ones");
    ram_mode = 2;
    run_op(1'b1, 7'd4, 27'd64, 32'd0, 32'd0, 1'b0, 1'b0, "add_wrap");
    ram_mode = 0;
    run_op(1'b0, 7'd7, 27'd112, 32'd112, 32'd1, 1'b1, 1'b0, "load_stall");
    run_op(1'b0, 7'd3, 27'd48, 32'd48, 32'd1, 1'b0, 1'b1, "load_glitch");
    reset_mid_fetch("rst_a");
    run_op(1'b1, 7'd2, 27'd32, 32'd32, 32'd1, 1'b0, 1'b0, "add_after_rst");
    reset_mid_fetch("rst_b");
    run_op(1'b0, 7'd2, 27'd32, 32'd32, 32'd1, 1'b0, 1'b0, "load_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/embedding_fetch.md
EMBEDDING_FETCH -- requirements
Module: embedding_fetch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of one embedding element.
REQ-002 The block SHALL have parameter DIM, default 16, meaning elements per embedding vector (>=2).
REQ-003 The block SHALL have parameter TOKEN_W, default 7, meaning the token index width.
REQ-004 The block SHALL have parameter ADDR_W, default 27, meaning the RAM word-address width.
REQ-005 The block SHALL have parameter RD_LAT, default 2, meaning the RAM read latency in cycles (>=1).
REQ-006 The block SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: request one fetch operation.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = LOAD (overwrite), 1 = ADD (accumulate into buffer).
REQ-010 The block SHALL have port token, input, TOKEN_W bits: token whose vector is fetched.
REQ-011 The block SHALL have port ram_en, output, 1 bit: read strobe.
REQ-012 The block SHALL have port ram_addr, output, ADDR_W bits: read word address.
REQ-013 The block SHALL have port ram_rdata, input, DATA_W bits: read data, RD_LAT cycles after the strobe.
REQ-014 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, DATA_W), out_index (output, clog2(DIM)) and out_last (output, 1), forming the result stream.
REQ-015 The block SHALL have ports busy (output, 1) and done (output, 1): operation in progress, and a one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, DRAIN, STREAM and DONE.
REQ-017 In IDLE, start=1 SHALL latch token and mode and move to FETCH; start SHALL be ignored in every other state.
REQ-018 The base address SHALL be token*DIM, zero-extended and truncated to ADDR_W bits (modulo 2^ADDR_W).
REQ-019 FETCH SHALL last exactly DIM cycles with ram_en=1 and ram_addr=base+i for i=0..DIM-1, in order, one per cycle.
REQ-020 Data for the read issued in cycle c SHALL be captured at the end of cycle c+RD_LAT into buffer[i].
REQ-021 LOAD SHALL write buffer[i]=ram_rdata; ADD SHALL write buffer[i]=buffer[i]+ram_rdata, two's-complement, wrapping modulo 2^DATA_W.
REQ-022 DRAIN SHALL hold ram_en=0 until the final (i=DIM-1) capture, then go to STREAM on the next edge.
REQ-023 STREAM SHALL present out_data=buffer[k], out_index=k for k=0..DIM-1, with out_last=1 only at k=DIM-1.
REQ-024 out_valid SHALL be 1 throughout STREAM, and k SHALL advance only on out_valid&&out_ready; data SHALL be stable while stalled.
REQ-025 The handshake with out_last=1 SHALL move to DONE; DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-026 busy SHALL be 1 in FETCH, DRAIN and STREAM, and 0 in IDLE and DONE.
REQ-027 The buffer SHALL persist across operations; only LOAD or reset SHALL overwrite it.
REQ-028 Minimum latency SHALL be: start sampled at edge T0, first out_valid in cycle T0+DIM+RD_LAT+1, assuming out_ready=1 throughout.

Reset
REQ-029 reset=1 SHALL force IDLE and clear the buffer, all counters and the read-data shift pipeline to 0, whatever the current state.
REQ-030 During reset, ram_en, out_valid, out_last, busy and done SHALL be 0, and ram_addr, out_data and out_index SHALL be 0.
REQ-031 Reset mid-operation SHALL abandon the operation without a done pulse; RAM returns still in flight SHALL be discarded.
REQ-032 The first start after reset deasserts SHALL be accepted normally.

Verification (DIM=16, RD_LAT=2, RAM model returns data = address)
REQ-033 LOAD with token=5, out_ready=1 -> ram_addr 80..95 on consecutive cycles; out_data 80..95 with out_index 0..15; out_last at index 15; done one cycle later.
REQ-034 After REQ-033, ADD with token=1 -> out_data[i] = (80+i)+(16+i) = 96+2i, for i=0..15.
REQ-035 Buffer preloaded to 0xFFFFFFFF by LOAD, then ADD with a location returning 1 -> out_data = 0x00000000 (wrap).
REQ-036 out_ready toggled 1,0,0,1,... during STREAM -> every index is delivered exactly once in order; out_data is stable while stalled; done follows the last handshake.
REQ-037 start pulsed during FETCH and STREAM -> no effect: exactly 16 reads and 16 outputs; the second token is never fetched.
REQ-038 reset asserted in cycle 8 of FETCH -> all outputs 0 in the next cycle; no done pulse; a following LOAD with token=2 yields 32..47.
